// File: rtl/spgd_pert_gen.sv
// -----------------------------------------------------------------------------
// spgd_pert_gen
//   N_CH-channel Gaussian-approximate perturbation generator for an SPGD loop.
//   Each channel owns a xorshift64 state. A vector is produced in four steps:
//     1. advance the state;
//     2. sum four M-bit slices (M = RNG_WIDTH-2) and centre the sum to get a
//        signed RNG_WIDTH-bit sample z (central limit theorem approximation);
//     3. form (z*SIGMA) >>> Z_FRAC and saturate it to FP_WIDTH bits;
//     4. present the result with a valid/ready handshake.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset (reloads seeds, abandons vector)
//   SIGMA       signed amplitude, captured when a request is accepted
//   REQ         request one vector (accepted when REQ && REQ_RDY)
//   REQ_RDY     high only while idle
//   PERT        channel i at [i*FP_WIDTH +: FP_WIDTH], signed
//   SAT         bit i set if channel i was clamped in this vector
//   PERT_VALID  PERT/SAT valid; held until PERT_READY
//   PERT_READY  consumer accept
//   PERT_NEG    (only with SPGD_PERT_ANTITHETIC_EN) saturating negation of PERT
//
// Optional feature macro: SPGD_PERT_ANTITHETIC_EN
// -----------------------------------------------------------------------------
module spgd_pert_gen #(
  parameter int          FP_WIDTH  = 64,
  parameter int          RNG_WIDTH = 14,
  parameter int          Z_FRAC    = 11,
  parameter int          N_CH      = 4,
  parameter logic [63:0] SEED_BASE = 64'h0123456789ABCDEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FP_WIDTH-1:0]      SIGMA,
  input  logic                     REQ,
  output logic                     REQ_RDY,
  output logic [N_CH*FP_WIDTH-1:0] PERT,
  output logic [N_CH-1:0]          SAT,
  output logic                     PERT_VALID,
`ifdef SPGD_PERT_ANTITHETIC_EN
  output logic [N_CH*FP_WIDTH-1:0] PERT_NEG,
`endif
  input  logic                     PERT_READY
);

  localparam int M  = RNG_WIDTH - 2;
  localparam int PW = FP_WIDTH + RNG_WIDTH;

  // Centring offset: the largest slice sum is 4*(2^M-1) = 2^RNG_WIDTH-4, so
  // subtracting 2^(RNG_WIDTH-1)-2 gives a symmetric range around zero.
  localparam logic [RNG_WIDTH-1:0] Z_OFS = RNG_WIDTH'((1 << (RNG_WIDTH-1)) - 2);

  localparam logic [FP_WIDTH-1:0]  P_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0]  P_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] Q_MAX = {{(RNG_WIDTH+1){1'b0}}, {(FP_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] Q_MIN = {{(RNG_WIDTH+1){1'b1}}, {(FP_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_MUL   = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_acc;
  logic [FP_WIDTH-1:0] sigma_q, sigma_d;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          req_acc = 1'b1;
          state_d = ST_GEN;
        end
      end
      ST_GEN:   state_d = ST_MUL;
      ST_MUL:   state_d = ST_VALID;
      ST_VALID: if (PERT_READY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sigma_d = sigma_q;
    if (req_acc) sigma_d = SIGMA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sigma_q <= '0;
    end else begin
      state_q <= state_d;
      sigma_q <= sigma_d;
    end
  end

  assign REQ_RDY    = (state_q == ST_IDLE);
  assign PERT_VALID = (state_q == ST_VALID);

  // ---------------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam logic [63:0] SEED_RAW = SEED_BASE ^ (64'(gi + 1) * 64'h9E3779B97F4A7C15);
      // xorshift64 has an all-zero fixed point, so a zero seed is replaced.
      localparam logic [63:0] SEED     = (SEED_RAW == 64'd0) ? 64'd1 : SEED_RAW;

      logic [63:0]                x_q, x_d;
      logic [63:0]                x_s1, x_s2, x_s3;
      logic [RNG_WIDTH-1:0]       s_sum;
      logic signed [RNG_WIDTH-1:0] z_q, z_d;
      logic signed [PW-1:0]       z_ext, s_ext, p_full, q_shr;
      logic [FP_WIDTH-1:0]        pert_new, pert_q, pert_d;
      logic                       sat_new, sat_q, sat_d;

      // State advances only on an accepted request, so GEN sees the new state.
      always_comb begin
        x_s1 = x_q  ^ (x_q  << 13);
        x_s2 = x_s1 ^ (x_s1 >> 7);
        x_s3 = x_s2 ^ (x_s2 << 17);
        x_d  = x_q;
        if (req_acc) x_d = x_s3;
      end

      // Slice sum fits in RNG_WIDTH unsigned bits; the centred result always
      // lies inside the signed RNG_WIDTH range, so modular subtraction is exact.
      always_comb begin
        s_sum = '0;
        for (int k = 0; k < 4; k++) begin
          s_sum = s_sum + {{(RNG_WIDTH-M){1'b0}}, x_q[16*k +: M]};
        end
        z_d = z_q;
        if (state_q == ST_GEN) z_d = s_sum - Z_OFS;
      end

      // Full-precision product cannot overflow PW bits: |z| < 2^(RNG_WIDTH-1)
      // and |SIGMA| <= 2^(FP_WIDTH-1).
      always_comb begin
        z_ext  = {{FP_WIDTH{z_q[RNG_WIDTH-1]}}, z_q};
        s_ext  = {{RNG_WIDTH{sigma_q[FP_WIDTH-1]}}, sigma_q};
        p_full = z_ext * s_ext;
        q_shr  = p_full >>> Z_FRAC;
        if (q_shr > Q_MAX) begin
          pert_new = P_MAX;
          sat_new  = 1'b1;
        end else if (q_shr < Q_MIN) begin
          pert_new = P_MIN;
          sat_new  = 1'b1;
        end else begin
          pert_new = q_shr[FP_WIDTH-1:0];
          sat_new  = 1'b0;
        end
      end

      // Outputs only change in MUL, so they stay stable under backpressure and
      // keep the last vector afterwards.
      always_comb begin
        pert_d = pert_q;
        sat_d  = sat_q;
        if (state_q == ST_MUL) begin
          pert_d = pert_new;
          sat_d  = sat_new;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          x_q    <= SEED;
          z_q    <= '0;
          pert_q <= '0;
          sat_q  <= 1'b0;
        end else begin
          x_q    <= x_d;
          z_q    <= z_d;
          pert_q <= pert_d;
          sat_q  <= sat_d;
        end
      end

      assign PERT[gi*FP_WIDTH +: FP_WIDTH] = pert_q;
      assign SAT[gi]                       = sat_q;

`ifdef SPGD_PERT_ANTITHETIC_EN
      logic [FP_WIDTH-1:0] neg_q, neg_d;

      // The most negative value has no positive counterpart; clamp to max.
      always_comb begin
        neg_d = neg_q;
        if (state_q == ST_MUL) neg_d = (pert_new == P_MIN) ? P_MAX : -pert_new;
      end

      always_ff @(posedge clk) begin
        if (rst) neg_q <= '0;
        else     neg_q <= neg_d;
      end

      assign PERT_NEG[gi*FP_WIDTH +: FP_WIDTH] = neg_q;
`endif
    end
  endgenerate

endmodule
